rca_seq_ctrl: RTL and testbench
===============================

// Module: rca_seq_ctrl
// PURPOSE
//  Multi-cycle sequencer that computes a WIDTH-bit sum a+b+c0 using one SLICE-bit
//  ripple-carry slice. The slice is reused over NSLICE=WIDTH/SLICE cycles, LSB slice
//  first, with a registered inter-slice carry. Uses a start/busy/done handshake.
//  Sits beside the full-width RCA as its area-reduced alternative in the adder datapath.
// PARAMETERS
//  WIDTH   32   operand/sum width; must be a positive multiple of SLICE
//  SLICE   8    width of the shared ripple-carry slice; NSLICE = WIDTH/SLICE >= 1
// PORTS
//  clk     in   1      single clock; all state updates on rising edge
//  rst_n   in   1      asynchronous, active-low reset
//  start   in   1      request; sampled only in IDLE or DONE
//  a       in   WIDTH  operand A; latched on the accepted-start edge
//  b       in   WIDTH  operand B; latched on the accepted-start edge
//  c0      in   1      carry-in; latched on the accepted-start edge
//  s       out  WIDTH  sum, registered; holds last result until next completion
//  c       out  1      carry-out of MSB slice, registered; updates with s
//  busy    out  1      1 while in RUN
//  done    out  1      one-cycle pulse; s/c are new in that cycle
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, idx=0, s=0, c=0, busy=0, done=0.
//    Operand/accumulator/carry regs are cleared. Any in-flight operation is discarded.
//  - States: IDLE, RUN, DONE.
//  - IDLE:
//    - start=1 -> latch a,b,c0; carry_r=c0; idx=0; go to RUN.
//    - start=0 -> stay.
//  - RUN, each edge:
//    - {cout, acc[idx*SLICE +: SLICE]} = a_r slice + b_r slice + carry_r.
//    - carry_r <= cout; idx <= idx+1.
//    - When idx==NSLICE-1: s <= completed acc, c <= cout, done <= 1, go to DONE.
//  - DONE (one cycle, done=1):
//    - start=1 -> accept new operands exactly as in IDLE (back-to-back, no bubble).
//    - start=0 -> go to IDLE.
//  - Latency: NSLICE clock edges from the accepted-start edge to the edge that raises done.
//    With defaults, start sampled at edge 0 gives done=1 in the cycle after edge 4.
//    Throughput is one result per NSLICE+1 cycles.
//  - start during RUN is ignored. Inputs a/b/c0 may change freely after acceptance.
//  - s and c never show partial results; they change only on the completion edge.
//  - busy is low in IDLE and DONE. done is low except in DONE.
//  - Arithmetic: s = (a+b+c0) mod 2^WIDTH; c = bit WIDTH of a+b+c0.
//    Carry must propagate across all slice boundaries.
//  - NSLICE==1: RUN lasts exactly one cycle.
//  - idx width is clog2(NSLICE), minimum 1. idx never wraps inside RUN.
// STRUCTURE
//  - Shared include adder_defs.vh: state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
//    and the clog2 helper.
//  - One sub-module, rca_slice: purely combinational SLICE-bit ripple-carry adder
//    (x, y, cin -> sum, cout), built from full-adder cells.
//  - Controller FSM, idx counter, operand regs and accumulator live in rca_seq_ctrl.
// TESTING
//  1. a=32'h02EB02EB, b=32'h555502EB, c0=0, start pulse
//     -> busy=1 for 4 cycles; done pulses once; s=32'h584005D6, c=0.
//  2. a=32'hFFFFFFFF, b=0, c0=1
//     -> s=32'h00000000, c=1 (carry crosses all 3 slice boundaries).
//  3. a=b=32'hFFFFFFFF, c0=1 -> s=32'hFFFFFFFF, c=1.
//     Then start held high through RUN: no re-accept until DONE.
//     Hold start=1 with new operands 1+1+0: accepted in DONE; next done gives s=2, c=0.
//  4. Start 32'h12345678+32'h11111111; drop rst_n low 2 cycles into RUN
//     -> s=0, c=0, busy=0, done=0 immediately.
//     After release: IDLE, no spurious done.
//  5. Change a/b/c0 every cycle during RUN
//     -> result equals operands latched at the start edge.
//     s/c stay at the old result until the done cycle.
//  6. Random 1000 ops vs reference model a+b+c0, with WIDTH=32/SLICE=8 and WIDTH=16/SLICE=16
//     -> all s/c match; done latency is always NSLICE edges.

Source files
------------

// File: rtl/rca_seq_ctrl_pkg.sv
// Shared definitions for the slice-serial adder: controller states, index-width helper
// and the full-adder cell used by the ripple slice.
package rca_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // ceil(log2(n)) with a floor of 1 so a single-slice build still has a usable index
    function automatic int unsigned idx_width(input int unsigned n);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) w = i + 1;
        end
        return (w == 0) ? 1 : w;
    endfunction

    function automatic logic [1:0] full_add(input logic x, input logic y, input logic cin);
        return {(x & y) | (cin & (x ^ y)), x ^ y ^ cin};
    endfunction

endpackage

// File: rtl/rca_seq_ctrl_slice.sv
// Purely combinational SLICE-bit ripple-carry adder built from full-adder cells.
module rca_slice
    import rca_seq_ctrl_pkg::*;
#(
    parameter int unsigned SLICE = 8
) (
    input  logic [SLICE-1:0] x,
    input  logic [SLICE-1:0] y,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout
);

    logic [SLICE:0] cy;

    always_comb begin
        cy    = '0;
        sum   = '0;
        cy[0] = cin;
        for (int unsigned i = 0; i < SLICE; i++) begin
            {cy[i+1], sum[i]} = full_add(x[i], y[i], cy[i]);
        end
        cout = cy[SLICE];
    end

endmodule

// File: rtl/rca_seq_ctrl.sv
// Slice-serial adder: one shared SLICE-bit ripple slice iterated LSB-first over
// WIDTH/SLICE cycles with a registered inter-slice carry; start/busy/done handshake.
module rca_seq_ctrl
    import rca_seq_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c0,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             busy,
    output logic             done
);

    localparam int unsigned     NSLICE   = WIDTH / SLICE;
    localparam int unsigned     IDXW     = idx_width(NSLICE);
    localparam int unsigned     BW       = idx_width(WIDTH);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    state_e           state_q;
    logic [IDXW-1:0]  idx_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] s_q;
    logic             c_q;
    logic             busy_q;
    logic             done_q;

    logic [BW-1:0]    base;
    logic [SLICE-1:0] slice_x;
    logic [SLICE-1:0] slice_y;
    logic [SLICE-1:0] slice_sum;
    logic             slice_cout;
    logic [WIDTH-1:0] acc_d;

    always_comb begin
        base                 = BW'(32'(idx_q) * SLICE);
        slice_x              = a_q[base +: SLICE];
        slice_y              = b_q[base +: SLICE];
        acc_d                = acc_q;
        acc_d[base +: SLICE] = slice_sum;
    end

    rca_slice #(
        .SLICE(SLICE)
    ) u_slice (
        .x   (slice_x),
        .y   (slice_y),
        .cin (carry_q),
        .sum (slice_sum),
        .cout(slice_cout)
    );

    // DONE shares the IDLE accept path so a held start re-launches with no bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            acc_q   <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= c0;
                        idx_q   <= '0;
                        acc_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    acc_q   <= acc_d;
                    carry_q <= slice_cout;
                    if (idx_q == LAST_IDX) begin
                        s_q     <= acc_d;
                        c_q     <= slice_cout;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        idx_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign s    = s_q;
    assign c    = c_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Scoreboard bench for rca_seq_ctrl in a 32/8 and a 16/16 build sharing one operand bus.
module tb_rca_seq_ctrl;

    localparam int unsigned NS0 = 4;
    localparam int unsigned NS1 = 1;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b1;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic [31:0] a_i    = '0;
    logic [31:0] b_i    = '0;
    logic        cin    = 1'b0;

    logic [31:0] s0;
    logic        c0o, busy0, done0;
    logic [15:0] s1;
    logic        c1o, busy1, done1;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc    = 0;

    logic [32:0] exp0_q[$];
    logic [32:0] exp1_q[$];
    int unsigned acc0_q[$];
    int unsigned acc1_q[$];
    logic [32:0] prev0, prev1;

    rca_seq_ctrl #(.WIDTH(32), .SLICE(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .a(a_i), .b(b_i), .c0(cin),
        .s(s0), .c(c0o), .busy(busy0), .done(done0)
    );

    rca_seq_ctrl #(.WIDTH(16), .SLICE(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a_i[15:0]), .b(b_i[15:0]), .c0(cin),
        .s(s1), .c(c1o), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev0 = {c0o, s0};
        end else begin
            if (done0) begin
                if (exp0_q.size() == 0) begin
                    check_eq("done0_spurious", 1, 0);
                end else begin
                    check_eq("sum0", {c0o, s0}, exp0_q.pop_front());
                    check_eq("lat0", cyc - acc0_q.pop_front(), NS0);
                    check_eq("busy0_at_done", busy0, 0);
                end
            end else begin
                check_eq("hold0", {c0o, s0}, prev0);
            end
            prev0 = {c0o, s0};
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev1 = {16'b0, c1o, s1};
        end else begin
            if (done1) begin
                if (exp1_q.size() == 0) begin
                    check_eq("done1_spurious", 1, 0);
                end else begin
                    check_eq("sum1", {16'b0, c1o, s1}, exp1_q.pop_front());
                    check_eq("lat1", cyc - acc1_q.pop_front(), NS1);
                    check_eq("busy1_at_done", busy1, 0);
                end
            end else begin
                check_eq("hold1", {16'b0, c1o, s1}, prev1);
            end
            prev1 = {16'b0, c1o, s1};
        end
    end

    // Called at a falling edge while the target DUT is in IDLE or DONE
    task automatic issue(input int sel, input logic [31:0] a, input logic [31:0] b, input logic ci);
        a_i = a;
        b_i = b;
        cin = ci;
        if (sel == 0) begin
            start0 = 1'b1;
            exp0_q.push_back(33'(a) + 33'(b) + 33'(ci));
            acc0_q.push_back(cyc + 1);
        end else begin
            start1 = 1'b1;
            exp1_q.push_back(33'(a[15:0]) + 33'(b[15:0]) + 33'(ci));
            acc1_q.push_back(cyc + 1);
        end
    endtask

    task automatic wait_done(input int sel);
        logic d;
        d = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            d = (sel == 0) ? done0 : done1;
            if (d) break;
        end
        if (!d) check_eq("timeout", 0, 1);
    endtask

    task automatic do_op(input int sel, input logic [31:0] a, input logic [31:0] b, input logic ci);
        issue(sel, a, b, ci);
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        wait_done(sel);
    endtask

    function automatic logic [31:0] rand_word();
        return ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : 32'($urandom);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int nbusy;

        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_s", s0, 0);
        check_eq("rst_c", c0o, 0);
        check_eq("rst_busy", busy0, 0);
        check_eq("rst_done", done0, 0);
        check_eq("rst_busy1", busy1, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // basic op with busy-length and single-pulse done
        issue(0, 32'h02EB02EB, 32'h555502EB, 1'b0);
        @(negedge clk);
        start0 = 1'b0;
        nbusy  = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy0) nbusy++;
            if (done0) break;
            @(negedge clk);
        end
        if (!done0) check_eq("t1_timeout", 0, 1);
        check_eq("t1_busy_cycles", nbusy, 4);
        check_eq("t1_sum", {c0o, s0}, {1'b1 & 1'b0, 32'h584005D6});
        @(negedge clk);
        check_eq("t1_done_pulse", done0, 0);

        // carry ripples through every slice boundary
        do_op(0, 32'hFFFFFFFF, 32'h00000000, 1'b1);
        check_eq("t2_sum", {c0o, s0}, {1'b1, 32'h00000000});

        // start held through RUN, re-accepted only in DONE
        issue(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        @(negedge clk);
        a_i = 32'd1;
        b_i = 32'd1;
        cin = 1'b0;
        wait_done(0);
        check_eq("t3_first", {c0o, s0}, {1'b1, 32'hFFFFFFFF});
        exp0_q.push_back(33'd2);
        acc0_q.push_back(cyc + 1);
        @(negedge clk);
        start0 = 1'b0;
        check_eq("t3_busy_b2b", busy0, 1);
        wait_done(0);
        check_eq("t3_second", {c0o, s0}, 33'd2);

        // reset in the middle of RUN discards the operation
        a_i    = 32'h12345678;
        b_i    = 32'h11111111;
        cin    = 1'b0;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("t4_s", s0, 0);
        check_eq("t4_c", c0o, 0);
        check_eq("t4_busy", busy0, 0);
        check_eq("t4_done", done0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_eq("t4_idle_done", done0, 0);
            check_eq("t4_idle_busy", busy0, 0);
        end

        // operands change every cycle after acceptance
        issue(0, 32'h0F0F0F0F, 32'h10101010, 1'b1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            start0 = 1'b0;
            if (done0) break;
            a_i = 32'($urandom);
            b_i = 32'($urandom);
            cin = 1'($urandom_range(0, 1));
        end
        if (!done0) check_eq("t5_timeout", 0, 1);
        check_eq("t5_sum", {c0o, s0}, {1'b0, 32'h1F1F1F20});

        // random back-to-back traffic on both builds
        for (int i = 0; i < 1000; i++) begin
            do_op(0, rand_word(), rand_word(), 1'($urandom_range(0, 1)));
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 1000; i++) begin
            do_op(1, rand_word(), rand_word(), 1'($urandom_range(0, 1)));
        end

        repeat (4) @(negedge clk);
        check_eq("sb0_empty", exp0_q.size(), 0);
        check_eq("sb1_empty", exp1_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
